bcd2bin_seq: RTL and testbench
==============================

BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 Parameter DIGITS, default 3, number of packed BCD digits on the input.
REQ-002 Parameter BIN_W, default 10, binary result width; the instantiating design SHALL ensure 2**BIN_W >= 10**DIGITS.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only when FSM is in IDLE or DONE.
REQ-006 bcd  input  4*DIGITS  packed BCD operand; bcd[3:0] is ones, bcd[7:4] is tens, bcd[11:8] is hundreds.
REQ-007 bin  output  BIN_W  binary result; registered, held until next accepted start.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse marking bin valid.
REQ-010 err  output  1  invalid-digit flag, valid with done.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-012 IDLE or DONE with start=1: latch bcd into the internal digit register, clear the internal binary shift register and the iteration counter, go to SHIFT, set busy=1.
REQ-013 Each SHIFT cycle: right-shift the {digits, binary} concatenation by one bit, then subtract 3 from every 4-bit digit whose value is >= 8 (reverse double-dabble), and increment the counter.
REQ-014 After exactly BIN_W SHIFT cycles: load bin from the binary shift register, go to DONE, set busy=0, set done=1.
REQ-015 DONE SHALL last one cycle, then return to IDLE unless start=1 (see REQ-012); done=0 in all other states.
REQ-016 Latency: an accepted start in cycle N gives done=1 in cycle N+BIN_W+1 (cycle N+11 at defaults).
REQ-017 start while in SHIFT SHALL be ignored; bcd changes during SHIFT SHALL NOT affect the result.
REQ-018 Back-to-back: start asserted in the DONE cycle SHALL be accepted with no idle gap.
REQ-019 bin and err SHALL change only on the edge that enters DONE, or on reset.
REQ-020 For every valid operand, bin SHALL equal the decimal value of bcd (0..10**DIGITS-1).

Reset
REQ-021 reset=1 SHALL force IDLE with bin=0, busy=0, done=0, err=0 and the counter cleared, on the next rising edge.
REQ-022 Reset during SHIFT SHALL abort the conversion; no done pulse for that request.
REQ-023 reset and start in the same cycle: reset wins; start is discarded.

Configuration
REQ-024 Macro BCD2BIN_DIGIT_CHECK_EN SHALL enable input-digit validation.
REQ-025 With BCD2BIN_DIGIT_CHECK_EN defined, an accepted start with any digit > 9 SHALL skip SHIFT: go directly to DONE in the next cycle (latency 1), with bin=0 and err=1; valid operands SHALL set err=0.
REQ-026 Without BCD2BIN_DIGIT_CHECK_EN, err SHALL be tied to 0 and every operand SHALL take the full BIN_W-cycle path; results for invalid digits are unchecked.

Verification
REQ-027 After reset, start with bcd=12'h000 -> done in cycle N+11, bin=0, err=0; busy high for cycles N+1..N+10.
REQ-028 bcd=12'h255 -> bin=10'd255; bcd=12'h999 -> bin=10'd999; bcd=12'h100 -> bin=10'd100.
REQ-029 Round trip: for i=0..255, drive bin2bcd with i and feed its bcd output into bcd2bin_seq -> bin==i for every i, using back-to-back starts in the DONE cycle.
REQ-030 Start bcd=12'h123, then hold start=1 with bcd=12'h456 through SHIFT -> first done gives bin=123; the next conversion starts in the DONE cycle and gives bin=456.
REQ-031 Start bcd=12'h500, assert reset in the 5th SHIFT cycle -> next cycle busy=0, bin=0, and no done pulse within 20 cycles.
REQ-032 With BCD2BIN_DIGIT_CHECK_EN, bcd=12'h1A3 -> done one cycle after start, err=1, bin=0; a following bcd=12'h042 -> bin=42, err=0.

Source files
------------

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble): done arrives BIN_W+1 cycles after an accepted start.
// Optional BCD2BIN_DIGIT_CHECK_EN: operands with any digit > 9 finish in one cycle with err=1 and bin=0.
module bcd2bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [BCD_W-1:0]           r_dig;
    logic [BIN_W-1:0]           r_sr;
    logic [CNT_W-1:0]           r_cnt;
    logic [BIN_W-1:0]           r_bin;
    logic [BCD_W+BIN_W-1:0]     w_shifted;
    logic [BCD_W-1:0]           w_dig_sh;
    logic [BCD_W-1:0]           w_dig_adj;
    logic                       w_accept;
    logic                       w_last;
    logic                       w_bad_digit;

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic r_err;

    always_comb begin
        w_bad_digit = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] > 4'd9) begin
                w_bad_digit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept && w_bad_digit) begin
            r_err <= 1'b1;
        end else if (r_state == SHIFT && w_last) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    assign w_bad_digit = 1'b0;
    assign err         = 1'b0;
`endif

    // One reverse double-dabble step: shift right, then pull every digit >= 8 back by 3.
    assign w_shifted = {r_dig, r_sr} >> 1;
    assign w_dig_sh  = w_shifted[BCD_W+BIN_W-1 -: BCD_W];

    always_comb begin
        w_dig_adj = w_dig_sh;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_dig_sh[4*k +: 4] >= 4'd8) begin
                w_dig_adj[4*k +: 4] = w_dig_sh[4*k +: 4] - 4'd3;
            end
        end
    end

    assign w_last = (r_cnt == CNT_W'(BIN_W - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_bad_digit ? DONE : SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_dig   <= '0;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_bin   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_dig <= bcd;
                r_sr  <= '0;
                r_cnt <= '0;
                if (w_bad_digit) begin
                    r_bin <= '0;
                end
            end else if (r_state == SHIFT) begin
                r_dig <= w_dig_adj;
                r_sr  <= w_shifted[BIN_W-1:0];
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_bin <= w_shifted[BIN_W-1:0];
                end
            end
        end
    end

    assign bin  = r_bin;
    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Bench for bcd2bin_seq: directed literal cases plus randomized traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_bcd2bin_seq;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] bcd;
    logic [9:0]  bin;
    logic        busy;
    logic        done;
    logic        err;

    bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bcd   (bcd),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int bcd_value(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit bcd_ok(input logic [11:0] b);
        return (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    // Reference model: a request counts down BIN_W busy cycles, then presents its decimal value.
    int m_cnt   = 0;
    int m_bin   = 0;
    int p_bin   = 0;
    bit m_done  = 1'b0;
    bit m_err   = 1'b0;
    bit m_known = 1'b0;
    bit p_known = 1'b0;
    bit m_live  = 1'b0;
    int n_done  = 0;

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            m_cnt = 0; m_done = 1'b0; m_err = 1'b0; m_bin = 0; m_known = 1'b1; m_live = 1'b1;
        end else if (m_live) begin
            if (m_cnt > 0) begin
                m_cnt--;
                m_done = (m_cnt == 0);
                if (m_cnt == 0) begin
                    m_bin = p_bin; m_known = p_known; m_err = 1'b0;
                end
            end else begin
                m_done = 1'b0;
                if (start === 1'b1) begin
                    if (CHECK_EN && !bcd_ok(bcd)) begin
                        m_done = 1'b1; m_bin = 0; m_err = 1'b1; m_known = 1'b1;
                    end else begin
                        m_cnt = BIN_W; p_bin = bcd_value(bcd); p_known = bcd_ok(bcd);
                    end
                end
            end
            if (m_done) n_done++;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("busy", busy, m_cnt > 0);
            check("done", done, m_done);
            check("err", err, m_err);
            if (m_known) check("bin", bin, m_bin);
        end
    end

    task automatic conv(input logic [11:0] v, output int lat, output int nbusy);
        start = 1'b1; bcd = v; lat = 0; nbusy = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0; bcd = 12'($urandom);
            end
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) check("conv_timeout", 0, 1);
    endtask

    task automatic wait_done(input bit drop_start, output int lat);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1 && drop_start) start = 1'b0;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nb;
        int seen;
        reset = 1'b1; start = 1'b0; bcd = '0;
        repeat (2) @(negedge clk);
        check("rst_bin", bin, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        @(negedge clk);

        conv(12'h000, lat, nb);
        check("z_lat", lat, 11); check("z_busy_cycles", nb, 10);
        check("z_bin", bin, 0); check("z_err", err, 0);
        conv(12'h255, lat, nb); check("d255_bin", bin, 255); check("d255_lat", lat, 11);
        conv(12'h999, lat, nb); check("d999_bin", bin, 999);
        conv(12'h100, lat, nb); check("d100_bin", bin, 100);

        // Start held high through the conversion: ignored while busy, accepted in DONE.
        start = 1'b1; bcd = 12'h123;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) bcd = 12'h456;
            if (done === 1'b1) begin lat = c; break; end
            lat = 0;
        end
        check("hold_first_lat", lat, 11); check("hold_first_bin", bin, 123);
        wait_done(1'b1, lat);
        check("hold_second_lat", lat, 11); check("hold_second_bin", bin, 456);

        // Abort in the 5th SHIFT cycle.
        start = 1'b1; bcd = 12'h500;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0); check("abort_bin", bin, 0); check("abort_done", done, 0);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("abort_no_done", seen, 0);

        // Round trip 0..255 with back-to-back starts in the DONE cycle.
        start = 1'b1; bcd = to_bcd(0);
        for (int i = 0; i < 256; i++) begin
            wait_done(1'b1, lat);
            check("rt_lat", lat, 11);
            check("rt_bin", bin, i);
            if (i < 255) begin
                start = 1'b1; bcd = to_bcd(i + 1);
            end
        end
        @(negedge clk);

`ifdef BCD2BIN_DIGIT_CHECK_EN
        conv(12'h1A3, lat, nb);
        check("inv_lat", lat, 1); check("inv_err", err, 1); check("inv_bin", bin, 0); check("inv_busy", nb, 0);
        conv(12'h042, lat, nb);
        check("v42_lat", lat, 11); check("v42_bin", bin, 42); check("v42_err", err, 0);
`endif

        // Randomized traffic: the reference model checks every cycle.
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) bcd = 12'($urandom);
            else bcd = to_bcd(int'($urandom_range(0, 999)));
        end
        reset = 1'b0; start = 1'b0;
        repeat (15) @(negedge clk);
        check("rand_activity", n_done > 100, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
